fir_coeff_loader: RTL and testbench

- Upstream companion to the parallel FIR. Takes coefficient words over a simple write stream into a shadow bank, then drives the FIR's packed 18-bit coefficient bus.
- Shadow bank is copied to the active bank only on a caller-supplied swap strobe, so the filter never sees a half-written coefficient set.
- coeff_o connects directly to the FIR coeff_i; update_o lets downstream logic flush or mark samples.

---
 rtl/fir_coeff_loader.sv | 150 +++++++++++++++
 tb/tb_fir_coeff_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_loader.sv
// Double-buffered coefficient loader feeding the parallel FIR coeff_i bus.
// Define FIR_COEFF_CHECKSUM_EN to require a trailing wrapping-sum word before a set can be armed.
module fir_coeff_loader #(
   parameter int                 taps          = 9,
   parameter logic [18*taps-1:0] DEFAULT_COEFF = (18*taps)'(18'h20000) << (18*(taps-1))
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  wr_i,
   input  logic [17:0]           data_i,
   input  logic                  swap_i,
   output logic [18*taps-1:0]    coeff_o,
   output logic                  busy_o,
   output logic                  armed_o,
   output logic                  update_o,
   output logic                  err_o
);

   localparam int CW = $clog2(taps + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
`ifdef FIR_COEFF_CHECKSUM_EN
      ST_CHECK,
`endif
      ST_ARMED
   } state_t;

   state_t                 state;
   logic [CW-1:0]          cnt;
   // Element taps-1 sits at the MSBs, so tap k lives in element taps-1-k.
   logic [taps-1:0][17:0]  shadow;
`ifdef FIR_COEFF_CHECKSUM_EN
   logic [17:0]            sum;
`endif

   // NOTE: all state here uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order in this block.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         // NOTE: the shadow bank is a flop array, not a RAM, so it can be
         // cleared on reset and copied to coeff_o in a single edge.
         shadow   <= '0;
         coeff_o  <= DEFAULT_COEFF;
         busy_o   <= 1'b0;
         armed_o  <= 1'b0;
         update_o <= 1'b0;
         err_o    <= 1'b0;
`ifdef FIR_COEFF_CHECKSUM_EN
         sum      <= '0;
`endif
      end else begin
         err_o    <= 1'b0;
         update_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  state   <= ST_LOAD;
                  cnt     <= '0;
                  busy_o  <= 1'b1;
`ifdef FIR_COEFF_CHECKSUM_EN
                  sum     <= '0;
`endif
               end else if (wr_i) begin
                  err_o   <= 1'b1;
               end
            end

            ST_LOAD: begin
               if (start_i) begin
                  err_o   <= 1'b1;
                  cnt     <= '0;
`ifdef FIR_COEFF_CHECKSUM_EN
                  sum     <= '0;
`endif
               end else if (wr_i) begin
                  for (int k = 0; k < taps; k++) begin
                     if (cnt == CW'(k)) shadow[taps-1-k] <= data_i;
                  end
                  cnt <= cnt + CW'(1);
`ifdef FIR_COEFF_CHECKSUM_EN
                  sum <= sum + data_i;
                  if (cnt == CW'(taps - 1)) state <= ST_CHECK;
`else
                  if (cnt == CW'(taps - 1)) begin
                     state   <= ST_ARMED;
                     busy_o  <= 1'b0;
                     armed_o <= 1'b1;
                  end
`endif
               end
            end

`ifdef FIR_COEFF_CHECKSUM_EN
            ST_CHECK: begin
               if (start_i) begin
                  state   <= ST_LOAD;
                  err_o   <= 1'b1;
                  cnt     <= '0;
                  sum     <= '0;
               end else if (wr_i) begin
                  busy_o  <= 1'b0;
                  if (data_i == sum) begin
                     state   <= ST_ARMED;
                     armed_o <= 1'b1;
                  end else begin
                     state   <= ST_IDLE;
                     shadow  <= '0;
                     err_o   <= 1'b1;
                  end
               end
            end
`endif

            ST_ARMED: begin
               // A restart outranks a simultaneous commit.
               if (start_i) begin
                  state   <= ST_LOAD;
                  cnt     <= '0;
                  busy_o  <= 1'b1;
                  armed_o <= 1'b0;
                  err_o   <= 1'b1;
`ifdef FIR_COEFF_CHECKSUM_EN
                  sum     <= '0;
`endif
               end else begin
                  if (wr_i) err_o <= 1'b1;
                  if (swap_i) begin
                     coeff_o  <= shadow;
                     update_o <= 1'b1;
                     armed_o  <= 1'b0;
                     state    <= ST_IDLE;
                  end
               end
            end

            default: begin
               state   <= ST_IDLE;
               busy_o  <= 1'b0;
               armed_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: directed scenarios plus a randomized run
// compared every cycle against a queue-based protocol model.
module tb_fir_coeff_loader;

   localparam int TAPS = 9;
   localparam int W    = 18 * TAPS;
`ifdef FIR_COEFF_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          start_i = 1'b0;
   logic          wr_i = 1'b0;
   logic [17:0]   data_i = '0;
   logic          swap_i = 1'b0;
   logic [W-1:0]  coeff_o;
   logic          busy_o, armed_o, update_o, err_o;

   fir_coeff_loader #(.taps(TAPS)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (start_i),
      .wr_i     (wr_i),
      .data_i   (data_i),
      .swap_i   (swap_i),
      .coeff_o  (coeff_o),
      .busy_o   (busy_o),
      .armed_o  (armed_o),
      .update_o (update_o),
      .err_o    (err_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Protocol model: a set is a list of accepted words; the bank is rebuilt from it on commit.
   logic [17:0]   m_words[$];
   bit            m_loading, m_armed;
   logic [W-1:0]  e_coeff;
   bit            e_busy, e_armed, e_update, e_err;

   function automatic logic [17:0] wrap_sum(input logic [17:0] q[$]);
      int unsigned s = 0;
      foreach (q[i]) s += q[i];
      return s[17:0];
   endfunction

   always @(posedge clk_i) begin
      if (rst_i) begin
         e_coeff = {18'h20000, {(W-18){1'b0}}};
         m_words.delete();
         m_loading = 0; m_armed = 0;
         e_err = 0; e_update = 0;
      end else begin
         e_err = 0; e_update = 0;
         if (start_i) begin
            e_err = m_loading || m_armed;
            m_words.delete();
            m_loading = 1; m_armed = 0;
         end else if (m_loading) begin
            if (wr_i) begin
               if (m_words.size() < TAPS) begin
                  m_words.push_back(data_i);
                  if (!CK && m_words.size() == TAPS) begin
                     m_loading = 0; m_armed = 1;
                  end
               end else if (data_i == wrap_sum(m_words)) begin
                  m_loading = 0; m_armed = 1;
               end else begin
                  m_loading = 0; e_err = 1; m_words.delete();
               end
            end
         end else if (m_armed) begin
            if (wr_i) e_err = 1;
            if (swap_i) begin
               for (int k = 0; k < TAPS; k++) e_coeff[18*(TAPS-k)-1 -: 18] = m_words[k];
               e_update = 1; m_armed = 0;
            end
         end else if (wr_i) begin
            e_err = 1;
         end
      end
      e_busy  = m_loading;
      e_armed = m_armed;
   end

   always @(negedge clk_i) begin
      if (chk_en) begin
         check("coeff_o",  coeff_o,  e_coeff);
         check("busy_o",   W'(busy_o),   W'(e_busy));
         check("armed_o",  W'(armed_o),  W'(e_armed));
         check("update_o", W'(update_o), W'(e_update));
         check("err_o",    W'(err_o),    W'(e_err));
      end
   end

   // Applies one cycle of inputs, then returns 2 time units after the edge.
   task automatic drive(input bit r, input bit s, input bit w, input logic [17:0] d, input bit sw);
      rst_i = r; start_i = s; wr_i = w; data_i = d; swap_i = sw;
      @(posedge clk_i); #2;
      rst_i = 0; start_i = 0; wr_i = 0; data_i = '0; swap_i = 0;
   endtask

   // Writes base, base+step, ...; with the checksum option also writes sum+ck_delta.
   task automatic load_seq(input logic [17:0] base, input logic [17:0] step, input logic [17:0] ck_delta);
      logic [17:0] w = base;
      logic [17:0] s = '0;
      for (int k = 0; k < TAPS; k++) begin
         drive(0, 0, 1, w, 0);
         s = s + w;
         w = w + step;
      end
      if (CK) drive(0, 0, 1, s + ck_delta, 0);
   endtask

   localparam logic [W-1:0] LIT_DEFAULT = {18'h20000, 144'h0};
   localparam logic [W-1:0] LIT_1_9     = {18'd1, 18'd2, 18'd3, 18'd4, 18'd5, 18'd6, 18'd7, 18'd8, 18'd9};
   localparam logic [W-1:0] LIT_10_18   = {18'd10, 18'd11, 18'd12, 18'd13, 18'd14, 18'd15, 18'd16, 18'd17, 18'd18};
   localparam logic [W-1:0] LIT_ONES    = {W{1'b1}};

   initial begin
      drive(1, 0, 0, 0, 0);
      chk_en = 1'b1;
      drive(1, 1, 1, 18'h1, 1);
      drive(0, 0, 0, 0, 0);
      check("rst_coeff",  coeff_o, LIT_DEFAULT);
      check("rst_update", W'(update_o), '0);
      check("rst_err",    W'(err_o), '0);

      // Basic load 1..9, idle a cycle, commit.
      drive(0, 1, 0, 0, 0);
      load_seq(18'd1, 18'd1, 18'd0);
      check("armed_after_last", W'(armed_o), W'(1));
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1);
      check("swap_coeff_1_9", coeff_o, LIT_1_9);
      check("swap_update",    W'(update_o), W'(1));
      drive(0, 0, 0, 0, 0);
      check("update_single",  W'(update_o), '0);

      // Restart mid-load, then all-ones set.
      drive(0, 1, 0, 0, 0);
      for (int k = 0; k < 4; k++) drive(0, 0, 1, 18'(k + 100), 0);
      drive(0, 1, 1, 18'h2AAAA, 0);
      check("restart_err", W'(err_o), W'(1));
      load_seq(18'h3FFFF, 18'd0, 18'd0);
      drive(0, 0, 0, 0, 1);
      check("swap_coeff_ones", coeff_o, LIT_ONES);

      // ARMED: start beats swap.
      drive(0, 1, 0, 0, 0);
      load_seq(18'd1, 18'd1, 18'd0);
      drive(0, 1, 0, 0, 1);
      check("armed_start_err",   W'(err_o), W'(1));
      check("armed_start_busy",  W'(busy_o), W'(1));
      check("armed_start_coeff", coeff_o, LIT_ONES);

      // Write in ARMED is refused and does not disturb the pending set.
      load_seq(18'd10, 18'd1, 18'd0);
      drive(0, 0, 1, 18'h12345, 0);
      check("armed_wr_err", W'(err_o), W'(1));
      drive(0, 0, 0, 0, 1);
      check("swap_coeff_10_18", coeff_o, LIT_10_18);

      // IDLE: write errors, swap is inert.
      drive(0, 0, 1, 18'h00777, 0);
      check("idle_wr_err", W'(err_o), W'(1));
      drive(0, 0, 0, 0, 1);
      check("idle_swap_update", W'(update_o), '0);
      check("idle_swap_coeff",  coeff_o, LIT_10_18);

      if (CK) begin
         drive(0, 1, 0, 0, 0);
         load_seq(18'd1, 18'd1, 18'h3FFFF);
         check("ck_bad_err",   W'(err_o), W'(1));
         check("ck_bad_armed", W'(armed_o), '0);
         check("ck_bad_busy",  W'(busy_o), '0);
         drive(0, 0, 0, 0, 1);
         check("ck_bad_swap", coeff_o, LIT_10_18);
      end

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         bit r  = ($urandom_range(0, 299) == 0);
         bit s  = ($urandom_range(0, 29) == 0);
         bit w  = ($urandom_range(0, 9) < 6);
         bit sw = ($urandom_range(0, 9) < 2);
         logic [17:0] d = 18'($urandom);
         if (CK && m_loading && m_words.size() == TAPS && $urandom_range(0, 1) == 1)
            d = wrap_sum(m_words);
         drive(r, s, w, d, sw);
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
